dial_quadrature_gen: RTL and testbench

//  Spinner emulator for one player. Converts held digital up/down joystick bits into the
//  2-bit Gray-code dial sequence the game board's control inputs expect. Has step timing
//  and hold acceleration. Sits between the joystick merge logic and the bagman joy_p1/joy_p2

---
 rtl/dial_quadrature_gen.sv | 165 ++++++++++++++++
 tb/tb_dial_quadrature_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dial_quadrature_gen.sv
// dial_quadrature_gen
// Spinner emulator for one player: turns held up/down joystick bits into the
// 2-bit Gray-code dial sequence the game board expects. The step period starts
// at STEP_DIV and halves after every ACCEL_STEPS consecutive held steps, never
// going below MIN_DIV. With spin_en low the joystick bits pass straight through
// (registered). Outputs are active-high; the board-level inversion lives upstream.
`timescale 1ns/1ps

module dial_quadrature_gen #(
    parameter int STEP_DIV    = 12000,
    parameter int MIN_DIV     = 3000,
    parameter int ACCEL_STEPS = 16,
    parameter int DIV_W       = 16
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             spin_en,
    input  logic             pause,
    input  logic             dir_up,
    input  logic             dir_down,
    output logic [1:0]       dial,
    output logic             step_pulse,
    output logic [DIV_W-1:0] cur_div
);

    localparam int ACC_W = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;

    localparam logic [DIV_W-1:0] STEP_DIV_V = DIV_W'(STEP_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV_V  = DIV_W'(MIN_DIV);
    localparam logic [ACC_W-1:0] ACC_LAST   = ACC_W'(ACCEL_STEPS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             down_q, down_d;       // direction of the current run: 1 = down
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       dial_q, dial_d;
    logic             pulse_q, pulse_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    logic             req_up;
    logic             req_dn;
    logic             req_any;
    logic [DIV_W-1:0] halved;

    // One Gray step: up walks 00->01->11->10, down walks the reverse.
    function automatic logic [1:0] gray_step(input logic [1:0] p, input logic down);
        if (down) begin
            gray_step = {~p[0], p[1]};
        end else begin
            gray_step = {p[0], ~p[1]};
        end
    endfunction

    assign req_up  = dir_up & ~dir_down;
    assign req_dn  = dir_down & ~dir_up;
    assign req_any = req_up | req_dn;
    assign halved  = cur_div_q >> 1;

    // Next-state logic: pause freezes everything, passthrough parks the spinner,
    // otherwise the IDLE/RUN machine paces the Gray steps.
    always_comb begin
        state_d   = state_q;
        down_d    = down_q;
        phase_d   = phase_q;
        dial_d    = dial_q;
        pulse_d   = 1'b0;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        acc_d     = acc_q;

        if (pause) begin
            // hold every register; only the strobe drops
        end else if (!spin_en) begin
            state_d   = ST_IDLE;
            down_d    = 1'b0;
            phase_d   = 2'b00;
            dial_d    = {dir_down, dir_up};
            cnt_d     = '0;
            cur_div_d = STEP_DIV_V;
            acc_d     = '0;
        end else begin
            dial_d = phase_q;
            case (state_q)
                ST_IDLE: begin
                    cnt_d     = '0;
                    acc_d     = '0;
                    cur_div_d = STEP_DIV_V;
                    if (req_any) begin
                        // first step of a press is emitted without waiting a period
                        state_d = ST_RUN;
                        down_d  = req_dn;
                        phase_d = gray_step(phase_q, req_dn);
                        pulse_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!req_any) begin
                        // release (or both held): stop, keep the current phase
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        acc_d     = '0;
                        cur_div_d = STEP_DIV_V;
                    end else if (req_dn != down_q) begin
                        // reversal behaves like a fresh press in the new direction
                        down_d    = req_dn;
                        phase_d   = gray_step(phase_q, req_dn);
                        pulse_d   = 1'b1;
                        cnt_d     = '0;
                        acc_d     = '0;
                        cur_div_d = STEP_DIV_V;
                    end else if (cnt_q == cur_div_q - DIV_W'(1)) begin
                        cnt_d   = '0;
                        phase_d = gray_step(phase_q, down_q);
                        pulse_d = 1'b1;
                        if (acc_q == ACC_LAST) begin
                            acc_d     = '0;
                            cur_div_d = (halved < MIN_DIV_V) ? MIN_DIV_V : halved;
                        end else begin
                            acc_d = acc_q + ACC_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous clear to the idle, full-period state.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            down_q    <= 1'b0;
            phase_q   <= 2'b00;
            dial_q    <= 2'b00;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
            cur_div_q <= STEP_DIV_V;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            down_q    <= down_d;
            phase_q   <= phase_d;
            dial_q    <= dial_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            acc_q     <= acc_d;
        end
    end

    assign dial       = dial_q;
    assign step_pulse = pulse_q;
    assign cur_div    = cur_div_q;

endmodule

// File: tb/tb_dial_quadrature_gen.sv
// Testbench for dial_quadrature_gen with a shortened step period so the
// acceleration and floor cases fit in a few hundred cycles.
`timescale 1ns/1ps

module tb_dial_quadrature_gen;

    localparam int SD   = 20;
    localparam int MD   = 5;
    localparam int ACC  = 4;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          spin_en = 1'b0;
    logic          pause = 1'b0;
    logic          up = 1'b0;
    logic          down = 1'b0;
    logic [1:0]    dial;
    logic          step_pulse;
    logic [DW-1:0] cur_div;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;

    dial_quadrature_gen #(
        .STEP_DIV    (SD),
        .MIN_DIV     (MD),
        .ACCEL_STEPS (ACC),
        .DIV_W       (DW)
    ) dut (
        .clk_sys    (clk),
        .reset      (rst),
        .spin_en    (spin_en),
        .pause      (pause),
        .dir_up     (up),
        .dir_down   (down),
        .dial       (dial),
        .step_pulse (step_pulse),
        .cur_div    (cur_div)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       spin_en;
        logic       pause;
        logic       up;
        logic       down;
        int         cycles;
        logic [1:0] dial;
        int         div;
        int         pulses;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] dial;
        int         div;
        int         pulses;
    } exp_t;

    localparam int NV = 27;
    vec_t vecs[NV];
    exp_t sb_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // step strobes seen on the falling edge
    always @(negedge clk) begin
        if (step_pulse === 1'b1) pulse_cnt++;
    end

    // in spinner mode each dial change must flip exactly one bit
    logic [1:0] prev_dial = 2'b00;
    logic       prev_ok = 1'b0;
    always @(negedge clk) begin
        if (!rst && spin_en && prev_ok && dial != prev_dial) begin
            checks++;
            if ($countones(dial ^ prev_dial) != 1) begin
                errors++;
                $display("FAIL gray_step: got %b after %b expected one-bit change", dial, prev_dial);
            end
        end
        prev_dial = dial;
        prev_ok   = !rst && spin_en;
    end

    task automatic apply(input int i);
        exp_t e;
        exp_t got;
        spin_en   = vecs[i].spin_en;
        pause     = vecs[i].pause;
        up        = vecs[i].up;
        down      = vecs[i].down;
        pulse_cnt = 0;
        e.idx = i; e.dial = vecs[i].dial; e.div = vecs[i].div; e.pulses = vecs[i].pulses;
        sb_q.push_back(e);
        repeat (vecs[i].cycles) @(negedge clk);
        #1;
        got = sb_q.pop_front();
        $display("vec %0d: spin=%b pause=%b up=%b dn=%b cyc=%0d -> dial=%b div=%0d pulses=%0d",
                 got.idx, vecs[i].spin_en, vecs[i].pause, vecs[i].up, vecs[i].down,
                 vecs[i].cycles, dial, cur_div, pulse_cnt);
        check($sformatf("vec%0d_dial", got.idx), int'(dial), int'(got.dial));
        check($sformatf("vec%0d_div", got.idx), int'(cur_div), got.div);
        check($sformatf("vec%0d_pulses", got.idx), pulse_cnt, got.pulses);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            spin pause up dn cyc  dial   div pulses
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  2'b01, SD, 0}; // passthrough up
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3,  2'b10, SD, 0}; // passthrough down
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2,  2'b11, SD, 0}; // passthrough both
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3,  2'b00, SD, 0}; // spinner idle
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  2'b00, SD, 1}; // press: step on first edge
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  2'b01, SD, 0}; // dial one clk later
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 18, 2'b01, SD, 0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  2'b01, SD, 1}; // second step at edge SD+1
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  2'b11, SD, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 39, 2'b10, SD, 2};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 20, 2'b00, SD/2, 1}; // first halving
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  2'b01, SD/2, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 40, 2'b01, MD, 4};   // second halving
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 20, 2'b01, MD, 4};   // floor holds
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  2'b01, SD, 1};   // reversal
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  2'b00, SD, 0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 30, 2'b00, SD, 0};   // both held: stop
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 5,  2'b00, SD, 0};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 10, 2'b00, SD, 0};   // paused press ignored
        vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  2'b00, SD, 1};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 10, 2'b10, SD, 0};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 7,  2'b10, SD, 0};   // pause mid-count
        vecs[22] = '{1'b1, 1'b0, 1'b0, 1'b1, 9,  2'b10, SD, 0};
        vecs[23] = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  2'b10, SD, 1};   // step delayed by 7
        vecs[24] = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  2'b11, SD, 0};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b1, 1,  2'b10, SD, 0};   // spinner aborted
        vecs[26] = '{1'b1, 1'b0, 1'b0, 1'b0, 2,  2'b00, SD, 0};   // restart at phase 00

        // reset state
        repeat (2) @(negedge clk);
        #1;
        $display("reset: dial=%b div=%0d pulse=%b", dial, cur_div, step_pulse);
        check("reset_dial", int'(dial), 0);
        check("reset_div", int'(cur_div), SD);
        check("reset_pulse", int'(step_pulse), 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) apply(i);

        // async reset right on a step strobe after one halving
        up = 1'b1;
        pulse_cnt = 0;
        repeat (4 * SD + 1) @(negedge clk);
        #1;
        $display("pre-reset A: dial=%b div=%0d pulse=%b", dial, cur_div, step_pulse);
        check("preA_pulse", int'(step_pulse), 1);
        check("preA_div", int'(cur_div), SD / 2);
        #2 rst = 1'b1;
        #1;
        $display("reset A: dial=%b div=%0d pulse=%b", dial, cur_div, step_pulse);
        check("rstA_pulse", int'(step_pulse), 0);
        check("rstA_div", int'(cur_div), SD);
        check("rstA_dial", int'(dial), 0);
        up = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;

        // async reset with a non-zero dial
        up = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("pre-reset B: dial=%b", dial);
        check("preB_dial", int'(dial), 1);
        #2 rst = 1'b1;
        #1;
        $display("reset B: dial=%b div=%0d pulse=%b", dial, cur_div, step_pulse);
        check("rstB_dial", int'(dial), 0);
        up = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
